// File: rtl/tick_count_seq_if.sv
// Tick-strobe consumer bus: strobe and mode controls in, count/speed/pulses out.
interface tick_count_seq_if;
  logic       tick_in;
  logic       en;
  logic       auto_mode;
  logic [1:0] speed_sel;
  logic [4:0] count;
  logic [1:0] speed;
  logic       step;
  logic       wrap;

  modport master (
    output tick_in, en, auto_mode, speed_sel,
    input  count, speed, step, wrap
  );

  modport slave (
    input  tick_in, en, auto_mode, speed_sel,
    output count, speed, step, wrap
  );
endinterface

// File: rtl/tick_count_seq.sv
// Prescaled 0..MAXV up-counter driven by a tick strobe.
// In auto mode the speed index advances on each wrap.
module tick_count_seq #(
  parameter int unsigned DIV0 = 1,
  parameter int unsigned DIV1 = 2,
  parameter int unsigned DIV2 = 4,
  parameter int unsigned DIV3 = 8,
  parameter int unsigned MAXV = 31
) (
  input  logic             clki,
  input  logic             reset,
  tick_count_seq_if.slave  bus
);

  localparam logic [4:0] MAX_COUNT = 5'(MAXV);

  logic [4:0] r_count;
  logic [1:0] r_speed;
  logic [7:0] r_prescale;
  logic       r_step;
  logic       r_wrap;

  logic [7:0] w_div;
  logic       w_accept;
  logic       w_resync;
  logic       w_at_max;
  logic [4:0] w_count_nxt;
  logic [1:0] w_speed_nxt;
  logic [7:0] w_prescale_nxt;
  logic       w_step_nxt;
  logic       w_wrap_nxt;

  always_comb begin
    unique case (r_speed)
      2'd0:    w_div = 8'(DIV0);
      2'd1:    w_div = 8'(DIV1);
      2'd2:    w_div = 8'(DIV2);
      default: w_div = 8'(DIV3);
    endcase
  end

  assign w_accept = bus.en & bus.tick_in;
  assign w_resync = ~bus.auto_mode & (bus.speed_sel != r_speed);
  assign w_at_max = (r_count == MAX_COUNT);

  // A manual speed change takes priority over any tick on the same edge.
  always_comb begin
    w_count_nxt    = r_count;
    w_speed_nxt    = r_speed;
    w_prescale_nxt = r_prescale;
    w_step_nxt     = 1'b0;
    w_wrap_nxt     = 1'b0;
    if (w_resync) begin
      w_speed_nxt    = bus.speed_sel;
      w_prescale_nxt = '0;
    end else if (w_accept) begin
      if (r_prescale == (w_div - 8'd1)) begin
        w_prescale_nxt = '0;
        w_count_nxt    = w_at_max ? '0 : r_count + 5'd1;
        w_step_nxt     = 1'b1;
        w_wrap_nxt     = w_at_max;
        if (bus.auto_mode && w_at_max) begin
          w_speed_nxt = r_speed + 2'd1;
        end
      end else begin
        w_prescale_nxt = r_prescale + 8'd1;
      end
    end
  end

  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_speed    <= '0;
      r_prescale <= '0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_speed    <= w_speed_nxt;
      r_prescale <= w_prescale_nxt;
      r_step     <= w_step_nxt;
      r_wrap     <= w_wrap_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.speed = r_speed;
  assign bus.step  = r_step;
  assign bus.wrap  = r_wrap;

endmodule
